cache_write_buffer: RTL
=======================

Name: cache_write_buffer

Overview:
Write-through store buffer between the set-associative cache's memory-side port and the memory/bus. Posted writes from the cache are granted and acknowledged without waiting for memory, then drained in order. Reads pass through only after the buffer has fully drained, which preserves read-after-write ordering. Upstream and downstream both use the core req/gnt/rvalid protocol.

Parameters:
DEPTH, 4, number of buffered write entries; power of two, >= 2.

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
up_addr_i  input  32  request address from cache
up_wdata_i  input  32  write data from cache
up_we_i  input  1  1 = write, 0 = read
up_req_i  input  1  request valid
up_be_i  input  4  byte enables
up_rdata_o  output  32  read data to cache
up_gnt_o  output  1  request accepted this cycle
up_rvalid_o  output  1  response valid, one pulse per granted request
up_error_o  output  1  response error; valid with up_rvalid_o
mem_addr_o  output  32  memory address
mem_wdata_o  output  32  memory write data
mem_we_o  output  1  memory write enable
mem_req_o  output  1  memory request
mem_be_o  output  4  memory byte enables
mem_rdata_i  input  32  memory read data
mem_gnt_i  input  1  memory grant
mem_rvalid_i  input  1  memory response valid
mem_error_i  input  1  memory response error
empty_o  output  1  no buffered writes and drain engine idle
drain_error_o  output  1  one-cycle pulse when a drained write returns mem_error_i

Behaviour:
- Reset: all outputs 0 except empty_o=1. FIFO pointers and count cleared. FSM goes to IDLE. Every output is registered except up_gnt_o.
- FIFO: DEPTH entries of {addr, wdata, be}. count has width clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Upstream gnt is combinational. It is blocked while rd_busy, where rd_busy = FSM in RD_REQ/RD_WAIT or a read response is pending this cycle.
  - Write: up_gnt_o = up_req_i & up_we_i & (count < DEPTH) & ~rd_busy. The full check uses the count at the start of the cycle, so a same-cycle pop does not free a slot. The accepted write is enqueued at that clock edge. up_rvalid_o=1 and up_error_o=0 on the next cycle.
  - Read: up_gnt_o = up_req_i & ~up_we_i & (count==0) & FSM==IDLE & ~rd_busy. Address and be are latched and the FSM moves to RD_REQ.
- Drain FSM (registered mem_* outputs):
  - IDLE: if a read was granted, go to RD_REQ with mem_req_o=1, mem_we_o=0, latched addr/be. Else if count>0, go to WR_REQ presenting the head entry with mem_we_o=1.
  - WR_REQ: hold mem_req_o and all mem_* stable until mem_gnt_i. On gnt: mem_req_o=0, pop the head, go to WR_WAIT.
  - WR_WAIT: on mem_rvalid_i, drain_error_o = mem_error_i for 1 cycle, go to IDLE.
  - RD_REQ: hold until mem_gnt_i, then mem_req_o=0 and go to RD_WAIT.
  - RD_WAIT: on mem_rvalid_i, capture up_rdata_o=mem_rdata_i and up_error_o=mem_error_i. up_rvalid_o=1 next cycle. Go to IDLE.
- Only one outstanding downstream transaction at a time. The minimum drain cost is 3 cycles per write (IDLE→REQ→WAIT) given immediate gnt and rvalid.
- up_rdata_o holds its last read value between reads. It is 0 after a write response.
- Ordering: writes drain FIFO-order. A read is never issued while any write is buffered or in flight.
- mem_gnt_i and mem_rvalid_i in the same cycle while in *_REQ: take the gnt, and capture rvalid in the next state only if rvalid is reasserted. Memory must not assert rvalid before gnt.
- Simultaneous enqueue and pop: count is unchanged and both pointers advance.
- empty_o = (count==0) & FSM==IDLE, registered.
- Reset mid-operation: buffered writes are discarded, mem_req_o drops immediately (asynchronous), and no pending up_rvalid_o is produced.

Test Plan:
- Single write 0x0000_1004/0xDEADBEEF/be=0xF, mem gnt+rvalid 1 cycle later → up_gnt same cycle, up_rvalid next cycle; mem write of same addr/data/be. empty_o returns to 1 after drain.
- 5 back-to-back writes, DEPTH=4, mem_gnt_i held 0 → first 4 granted, 5th gnt=0. Release gnt → 5th granted once a slot frees. Memory sees all 5 addresses in order.
- Write 0x100←0x11 then read 0x100 → read gnt withheld until write drained. mem read issued afterwards. up_rdata_o=mem_rdata_i (0x11), up_rvalid 1 cycle after mem_rvalid.
- Write drained with mem_error_i=1 → drain_error_o single-cycle pulse; up_error_o stays 0 for that write.
- Read outstanding then upstream write request → gnt=0 until read response delivered; then write granted.
- Assert reset with 3 buffered writes and mem_req_o high → mem_req_o=0 immediately, count=0, empty_o=1; no further mem transactions.

Source files
------------

// File: rtl/cache_write_buffer.sv
// Posted-write store buffer between the cache memory port and the bus.
// Writes are acknowledged on enqueue and drained in order; reads pass only once empty.
module cache_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] up_addr_i,
  input  logic [31:0] up_wdata_i,
  input  logic        up_we_i,
  input  logic        up_req_i,
  input  logic [3:0]  up_be_i,
  output logic [31:0] up_rdata_o,
  output logic        up_gnt_o,
  output logic        up_rvalid_o,
  output logic        up_error_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_we_o,
  output logic        mem_req_o,
  output logic [3:0]  mem_be_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic        mem_error_i,
  output logic        empty_o,
  output logic        drain_error_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } entry_t;

  state_t        state_q, state_d;
  entry_t        fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          rd_resp_q, rd_resp_d;
  logic          rd_busy, wr_gnt, rd_gnt, push, pop;

  logic [31:0]   mem_addr_d, mem_wdata_d, up_rdata_d;
  logic [3:0]    mem_be_d;
  logic          mem_we_d, mem_req_d, up_rvalid_d, up_error_d, drain_error_d, empty_d;

  // rd_resp_q marks the cycle the read response is on the upstream port.
  assign rd_busy  = (state_q == RD_REQ) || (state_q == RD_WAIT) || rd_resp_q;
  assign wr_gnt   = up_req_i && up_we_i && (count_q < FULL_CNT) && !rd_busy;
  assign rd_gnt   = up_req_i && !up_we_i && (count_q == '0) && (state_q == IDLE) && !rd_busy;
  assign up_gnt_o = wr_gnt || rd_gnt;
  assign push     = wr_gnt;
  assign pop      = (state_q == WR_REQ) && mem_gnt_i;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (rd_gnt)              state_d = RD_REQ;
        else if (count_q != '0)  state_d = WR_REQ;
      end
      WR_REQ:  if (mem_gnt_i)    state_d = WR_WAIT;
      WR_WAIT: if (mem_rvalid_i) state_d = IDLE;
      RD_REQ:  if (mem_gnt_i)    state_d = RD_WAIT;
      RD_WAIT: if (mem_rvalid_i) state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_addr_d    = mem_addr_o;
    mem_wdata_d   = mem_wdata_o;
    mem_be_d      = mem_be_o;
    mem_we_d      = mem_we_o;
    mem_req_d     = mem_req_o;
    up_rvalid_d   = 1'b0;
    up_error_d    = 1'b0;
    up_rdata_d    = up_rdata_o;
    drain_error_d = 1'b0;
    rd_resp_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd_gnt) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = up_addr_i;
          mem_wdata_d = '0;
          mem_be_d    = up_be_i;
        end else if (count_q != '0) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = fifo_q[rd_ptr_q].addr;
          mem_wdata_d = fifo_q[rd_ptr_q].wdata;
          mem_be_d    = fifo_q[rd_ptr_q].be;
        end
      end
      WR_REQ:  if (mem_gnt_i) mem_req_d = 1'b0;
      WR_WAIT: if (mem_rvalid_i) drain_error_d = mem_error_i;
      RD_REQ:  if (mem_gnt_i) mem_req_d = 1'b0;
      RD_WAIT: begin
        if (mem_rvalid_i) begin
          up_rvalid_d = 1'b1;
          up_error_d  = mem_error_i;
          up_rdata_d  = mem_rdata_i;
          rd_resp_d   = 1'b1;
        end
      end
      default: mem_req_d = 1'b0;
    endcase
    // Posted write: acknowledged on the cycle after enqueue, never with an error.
    if (wr_gnt) begin
      up_rvalid_d = 1'b1;
      up_error_d  = 1'b0;
      up_rdata_d  = '0;
    end
  end

  assign empty_d = (count_d == '0) && (state_d == IDLE);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      rd_resp_q     <= 1'b0;
      mem_addr_o    <= '0;
      mem_wdata_o   <= '0;
      mem_be_o      <= '0;
      mem_we_o      <= 1'b0;
      mem_req_o     <= 1'b0;
      up_rvalid_o   <= 1'b0;
      up_error_o    <= 1'b0;
      up_rdata_o    <= '0;
      drain_error_o <= 1'b0;
      empty_o       <= 1'b1;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      rd_resp_q     <= rd_resp_d;
      mem_addr_o    <= mem_addr_d;
      mem_wdata_o   <= mem_wdata_d;
      mem_be_o      <= mem_be_d;
      mem_we_o      <= mem_we_d;
      mem_req_o     <= mem_req_d;
      up_rvalid_o   <= up_rvalid_d;
      up_error_o    <= up_error_d;
      up_rdata_o    <= up_rdata_d;
      drain_error_o <= drain_error_d;
      empty_o       <= empty_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // NOTE: storage is not reset; an entry is only read after being written behind the count.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{addr: up_addr_i, wdata: up_wdata_i, be: up_be_i};
  end

endmodule
